// File: rtl/wf_7seg_pkg.sv
// -----------------------------------------------------------------------------
// wf_7seg_pkg
// Shared types and constants for the two-requester 7-segment display arbiter.
//   state_e  : arbiter FSM states (IDLE / OWN_A / OWN_B)
//   owner_e  : encoding of the most recent display owner (round-robin memory)
//   disp_t   : registered display image (four BCD digits plus colon code)
//   COLON_*  : colon codes understood by the 7-segment interface
// -----------------------------------------------------------------------------
package wf_7seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_e;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_e;

  localparam logic [1:0] COLON_TIME = 2'b00;
  localparam logic [1:0] COLON_DP   = 2'b01;
  localparam logic [1:0] COLON_NONE = 2'b11;

  typedef struct packed {
    logic [15:0] digits;  // {d3,d2,d1,d0}
    logic [1:0]  colon;
  } disp_t;

  // On a tie from IDLE the requester that did not own the display last wins.
  function automatic state_e tie_winner(owner_e last_owner);
    return (last_owner == OWNER_A) ? OWN_B : OWN_A;
  endfunction

endpackage

// File: rtl/wf_slice_counter.sv
// -----------------------------------------------------------------------------
// wf_slice_counter
// Counts timebase ticks for the current display owner and flags when the
// owner has used up its slice.
//   clk, rst_n : system clock, asynchronous active-low reset
//   clear_i    : state entry this cycle; counter restarts from 0 (wins over tick)
//   en_i       : an owner holds the display, so ticks are counted
//   tick_i     : one-cycle timebase pulse
//   at_max_o   : counter has reached MAX_TICKS (it saturates there)
// -----------------------------------------------------------------------------
module wf_slice_counter
  import wf_7seg_pkg::*;
#(
  parameter int MAX_TICKS = 100,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  input  logic tick_i,
  output logic at_max_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TICKS);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] slice_q, slice_d;

  assign at_max_o = (slice_q == MAX_CNT);

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    slice_d = slice_q;
    if (clear_i) begin
      slice_d = '0;
    end else if (en_i && tick_i && !at_max_o) begin
      slice_d = slice_q + ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slice_q <= '0;
    end else begin
      slice_q <= slice_d;
    end
  end

endmodule

// File: rtl/wf_7seg_arbiter.sv
// -----------------------------------------------------------------------------
// wf_7seg_arbiter
// Arbitrates a single 4-digit 7-segment display between requesters A and B.
// An uncontended owner keeps the display forever; a contended owner is
// preempted after MAX_TICKS timebase ticks. Handovers are atomic (no IDLE
// cycle) and ties from IDLE are resolved round-robin.
//   clk, rst_n              : system clock, asynchronous active-low reset
//   tick                    : one-cycle timebase pulse
//   req_a, data_a, colon_a  : requester A request, BCD digits, colon code
//   req_b, data_b, colon_b  : requester B request, BCD digits, colon code
//   gnt_a, gnt_b            : current owner (never both high)
//   digit0..digit3, colon   : registered display image of the owner
//   preempt                 : one-cycle pulse after a forced transfer
// -----------------------------------------------------------------------------
module wf_7seg_arbiter
  import wf_7seg_pkg::*;
#(
  parameter int MAX_TICKS = 100,
  parameter int CNT_W     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        req_a,
  input  logic [15:0] data_a,
  input  logic [1:0]  colon_a,
  input  logic        req_b,
  input  logic [15:0] data_b,
  input  logic [1:0]  colon_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic [3:0]  digit0,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic [3:0]  digit3,
  output logic [1:0]  colon,
  output logic        preempt
);

  state_e state_q, state_d;
  owner_e last_q, last_d;
  logic   preempt_q, preempt_d;
  disp_t  disp_q, disp_d;
  logic   at_max;
  logic   state_entry;

  assign state_entry = (state_d != state_q);

  wf_slice_counter #(
    .MAX_TICKS (MAX_TICKS),
    .CNT_W     (CNT_W)
  ) u_slice (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (state_entry),
    .en_i     (state_q != IDLE),
    .tick_i   (tick),
    .at_max_o (at_max)
  );

  // ---------------------------------------------------------------------------
  // State register (also holds round-robin memory and the preempt pulse)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= OWNER_B;  // so A wins the first tie
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      preempt_q <= preempt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // A release (own request low) is checked before the slice limit, so a
  // release coinciding with slice==MAX hands over without a preempt pulse.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    preempt_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_a && req_b) begin
          state_d = tie_winner(last_q);
        end else if (req_a) begin
          state_d = OWN_A;
        end else if (req_b) begin
          state_d = OWN_B;
        end
      end
      OWN_A: begin
        if (!req_a) begin
          state_d = req_b ? OWN_B : IDLE;
        end else if (req_b && at_max) begin
          state_d   = OWN_B;
          preempt_d = 1'b1;
        end
      end
      OWN_B: begin
        if (!req_b) begin
          state_d = req_a ? OWN_A : IDLE;
        end else if (req_a && at_max) begin
          state_d   = OWN_A;
          preempt_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Round-robin memory follows every entry into an owning state.
  always_comb begin
    last_d = last_q;
    if (state_entry && state_d == OWN_A) begin
      last_d = OWNER_A;
    end else if (state_entry && state_d == OWN_B) begin
      last_d = OWNER_B;
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt_a   = (state_q == OWN_A);
    gnt_b   = (state_q == OWN_B);
    preempt = preempt_q;
    digit0  = disp_q.digits[3:0];
    digit1  = disp_q.digits[7:4];
    digit2  = disp_q.digits[11:8];
    digit3  = disp_q.digits[15:12];
    colon   = disp_q.colon;
  end

  // Display image: follows the owner one clock late, switches to the new
  // owner on the handover edge itself, and freezes while IDLE. Nibbles are
  // copied verbatim, BCD or not.
  always_comb begin
    disp_d = disp_q;
    unique case (state_q)
      OWN_A:   disp_d = (state_d == OWN_B) ? '{digits: data_b, colon: colon_b}
                                           : '{digits: data_a, colon: colon_a};
      OWN_B:   disp_d = (state_d == OWN_A) ? '{digits: data_a, colon: colon_a}
                                           : '{digits: data_b, colon: colon_b};
      default: disp_d = disp_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q <= '{digits: 16'h0000, colon: COLON_NONE};
    end else begin
      disp_q <= disp_d;
    end
  end

endmodule

// File: doc/wf_7seg_arbiter.md
WF_7SEG_ARBITER -- requirements
Module: wf_7seg_arbiter

Interface
REQ-001 The parameters SHALL be, one per line: name, default, meaning.
- MAX_TICKS, 100, slice length in tick pulses before a contended owner is preempted (1..255).
- CNT_W, 8, slice counter width.
REQ-002 The ports SHALL be, one per line: name, direction, width, meaning. clk and rst_n come first.
- clk  in  1  single system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle timebase pulse (e.g. 10 ms strobe).
- req_a  in  1  requester A wants the display.
- data_a  in  16  requester A BCD digits {d3,d2,d1,d0}.
- colon_a  in  2  requester A colon code.
- req_b, data_b, colon_b  in  1/16/2  the same for requester B.
- gnt_a  out  1  A owns the display.
- gnt_b  out  1  B owns the display.
- digit0..digit3  out  4 each  digits to the 4-digit 7-seg interface.
- colon  out  2  colon code to the 7-seg interface (00 colon, 01 dp, 11 none).
- preempt  out  1  one-cycle pulse when ownership is forcibly transferred.

Function
REQ-003 The FSM SHALL have states IDLE, OWN_A, OWN_B; gnt_a=1 only in OWN_A and gnt_b=1 only in OWN_B; they SHALL never both be 1.
REQ-004 IDLE: req_a&~req_b -> OWN_A; ~req_a&req_b -> OWN_B; both -> the requester not in last_owner; neither -> stay.
REQ-005 OWN_A: ~req_a&req_b -> OWN_B; ~req_a&~req_b -> IDLE; req_a&req_b&(slice==MAX_TICKS) -> OWN_B with preempt=1; otherwise stay. OWN_B mirrors this.
REQ-006 A handover SHALL be atomic: the old grant falls and the new grant rises on the same edge, with no IDLE cycle.
REQ-007 last_owner SHALL update to the new owner on every entry to OWN_A/OWN_B.
REQ-008 slice SHALL clear to 0 on every state entry, increment on tick while in an OWN state, and saturate at MAX_TICKS.
REQ-009 An uncontended owner SHALL keep its grant indefinitely regardless of slice.
REQ-010 In an OWN state, the outputs (digit0..3, colon) SHALL register the owner's data/colon every cycle, one clock latency; data_a[3:0] maps to digit0.
REQ-011 On the handover edge, the outputs SHALL load the new owner's data.
REQ-012 In IDLE, the outputs SHALL hold their last value.
REQ-013 Non-BCD nibbles SHALL pass through unmodified.
REQ-014 If tick coincides with the preempting edge, the new slice SHALL be 0; tick is not counted.
REQ-015 A req deasserted on the same cycle slice reaches MAX_TICKS SHALL be treated as a release: preempt stays 0.

Reset
REQ-016 While rst_n=0, asynchronously: state=IDLE, gnt_a=gnt_b=0, digits=4'h0, colon=2'b11, preempt=0, slice=0, last_owner=B (A wins the first tie).
REQ-017 Reset asserted mid-ownership SHALL drop the grant immediately, without waiting for a clock.
REQ-018 The first arbitration after rst_n rises SHALL occur on the first clock edge.

Structure
REQ-019 Package wf_7seg_pkg SHALL hold the state enum (IDLE/OWN_A/OWN_B), the colon constants COLON_TIME=2'b00, COLON_DP=2'b01, COLON_NONE=2'b11, and the owner encoding.
REQ-020 The slice counter (clear, tick-enable, saturate, at_max flag) SHALL be sub-module wf_slice_counter; everything else SHALL be in the top.

Verification
REQ-021 Reset then req_a=1, data_a=16'h1234 -> gnt_a=1 after 1 edge; digit3..0 = 1,2,3,4 on the next edge; preempt=0.
REQ-022 From IDLE, req_a and req_b raised on the same cycle -> OWN_A. After A releases and both re-request from IDLE -> OWN_B (round robin).
REQ-023 MAX_TICKS=3, A owns, B requests, tick every 5 cycles -> after the 3rd tick, the next edge gives gnt_a=0, gnt_b=1, preempt pulse of one cycle, and outputs = data_b.
REQ-024 A alone holds for 1000 ticks -> no change of grant and no preempt.
REQ-025 A owns with B pending, req_a falls on the same cycle slice hits MAX -> gnt_b=1 with preempt=0. Then B falls with A idle -> IDLE and the outputs still show the last data_b.
REQ-026 rst_n pulsed low mid-OWN_B -> gnt_b=0 before the next clk, colon=2'b11, digits=0.
